// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder and its storage array.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } state_t;

    localparam int unsigned LANE_W           = 32;
    localparam int unsigned NUM_LANES        = 2;
    localparam int unsigned READ_LAT_DEFAULT = 2;
    localparam int unsigned LAT_W            = 4;

    localparam int unsigned LO = 0;
    localparam int unsigned HI = 1;

endpackage

// File: rtl/sram_storage.sv
// Word array with per-lane write mask and a registered, resettable read port.
module sram_storage
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [NUM_LANES-1:0]  i_wr_mask,
    input  logic [DEPTH_LOG2-1:0] i_wr_idx,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_idx,
    output logic [DATA_W-1:0]     o_rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (i_wr_mask[l]) begin
                    r_mem[i_wr_idx][l*LANE_W +: LANE_W] <= i_wr_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_responder.sv
// Async-SRAM pin-level responder: read-latency FSM, lane-masked writes and
// combinationally gated tristate drive of the data bus.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned READ_LAT   = READ_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_UB_N,
    output logic              rd_valid,
    output logic              busy
);

    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [LAT_W-1:0]   w_lat_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr_q;
    logic [ADDR_W-1:0]  w_addr_q_nxt;
    logic               w_latch;
    logic               w_wr;
    logic               w_rd_req;
    logic               w_addr_hit;
    logic               w_drive_lo;
    logic               w_drive_hi;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_wr       = ~SRAM_CE_N & ~SRAM_WE_N;
    assign w_rd_req   = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;
    assign w_addr_hit = (SRAM_ADDR == r_addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_addr_q  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_addr_q  <= w_addr_q_nxt;
        end
    end

    // A write always wins and drops any read in flight; otherwise losing the
    // read strobes aborts and a new address restarts the latency count.
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_addr_q_nxt  = r_addr_q;
        w_latch       = 1'b0;
        if (w_wr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_req) begin
                        w_state_nxt   = RD_WAIT;
                        w_addr_q_nxt  = SRAM_ADDR;
                        w_lat_cnt_nxt = LAT_RELOAD;
                    end
                end
                RD_WAIT, RD_DRIVE: begin
                    if (!w_rd_req) begin
                        w_state_nxt = IDLE;
                    end else if (!w_addr_hit) begin
                        w_state_nxt   = RD_WAIT;
                        w_addr_q_nxt  = SRAM_ADDR;
                        w_lat_cnt_nxt = LAT_RELOAD;
                    end else if (r_state == RD_WAIT) begin
                        if (r_lat_cnt == '0) begin
                            w_latch     = 1'b1;
                            w_state_nxt = RD_DRIVE;
                        end else begin
                            w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    sram_storage #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_storage (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_mask ({~SRAM_UB_N, ~SRAM_LB_N}),
        .i_wr_idx  (SRAM_ADDR[DEPTH_LOG2-1:0]),
        .i_wr_data (SRAM_DQ),
        .i_rd_en   (w_latch),
        .i_rd_idx  (r_addr_q[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Drive is gated by live strobes so the bus frees in the cycle OE_N rises.
    assign rd_valid   = (r_state == RD_DRIVE) & w_rd_req;
    assign busy       = (r_state != IDLE);
    assign w_drive_lo = rd_valid & ~SRAM_LB_N;
    assign w_drive_hi = rd_valid & ~SRAM_UB_N;

    assign SRAM_DQ[LO*LANE_W +: LANE_W] = w_drive_lo ? w_rd_data[LO*LANE_W +: LANE_W] : {LANE_W{1'bz}};
    assign SRAM_DQ[HI*LANE_W +: LANE_W] = w_drive_hi ? w_rd_data[HI*LANE_W +: LANE_W] : {LANE_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: stimulus queues expected read bursts,
// a negedge monitor checks each rising rd_valid against the queue head.
module tb_sram_responder;

    localparam int unsigned LAT = 2;

    localparam logic [63:0] V1 = 64'h1122_3344_99AA_BBCC;
    localparam logic [63:0] V2 = 64'h1122_3344_CAFE_BABE;
    localparam logic [63:0] V3 = 64'h5566_7788_0102_0304;
    localparam logic [63:0] V4 = 64'hA5A5_0F0F_3C3C_7E7E;
    localparam logic [63:0] V5 = 64'h0BAD_F00D_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] addr;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    logic [63:0] tb_dq;
    logic        tb_dq_en;
    wire  [63:0] dq;
    logic        rd_valid, busy;

    assign dq = tb_dq_en ? tb_dq : {64{1'bz}};

    typedef struct {
        logic [63:0] data;
        logic        lo_en;
        logic        hi_en;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    logic prev_v = 1'b0;
    bit   ok;

    sram_responder #(
        .ADDR_W     (17),
        .DATA_W     (64),
        .DEPTH_LOG2 (10),
        .READ_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (addr),
        .SRAM_DQ   (dq),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_LB_N (lb_n),
        .SRAM_UB_N (ub_n),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit released(input logic [31:0] v);
        return (v === {32{1'bz}}) || (v === 32'h0);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_rel(input string name, input logic [31:0] v);
        n_cmp++;
        if (!released(v)) begin
            n_bad++;
            $display("FAIL %s: got %h want released lane", name, v);
        end
    endtask

    task automatic idle_bus();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        lb_n = 1'b0; ub_n = 1'b0; tb_dq_en = 1'b0;
    endtask

    task automatic push_exp(input logic [63:0] d, input logic lo, input logic hi);
        exp_t x;
        x.data = d; x.lo_en = lo; x.hi_en = hi; x.due = cyc + 1 + LAT;
        q.push_back(x);
    endtask

    task automatic do_write(input logic [16:0] a, input logic [63:0] d, input logic lb, input logic ub);
        step();
        addr = a; tb_dq = d; tb_dq_en = 1'b1;
        lb_n = lb; ub_n = ub; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic start_read(input logic [16:0] a, input logic lb, input logic ub,
                              input logic [63:0] d, input bit expect_it);
        step();
        addr = a; lb_n = lb; ub_n = ub; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
        if (expect_it) push_exp(d, !lb, !ub);
    endtask

    // Monitor: one queued expectation per rising rd_valid (data, lanes, latency).
    always @(negedge clk) begin
        if (rd_valid && !prev_v) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: dq=%h at cycle %0d, nothing queued", dq, cyc);
            end else begin
                e  = q.pop_front();
                ok = (cyc == e.due);
                if (e.lo_en) ok = ok && (dq[31:0]  === e.data[31:0]);
                else         ok = ok && released(dq[31:0]);
                if (e.hi_en) ok = ok && (dq[63:32] === e.data[63:32]);
                else         ok = ok && released(dq[63:32]);
                if (!ok) begin
                    n_bad++;
                    $display("FAIL read_data: got %h at cycle %0d want %h (lanes hi=%0b lo=%0b) at cycle %0d",
                             dq, cyc, e.data, e.hi_en, e.lo_en, e.due);
                end
            end
        end
        prev_v = rd_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        addr  = '0;
        tb_dq = '0;
        rst   = 1'b1;
        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_rd_valid", rd_valid, 0);
        check_rel("reset_dq_lo", dq[31:0]);
        check_rel("reset_dq_hi", dq[63:32]);
        rst = 1'b0;

        do_write(17'h005, V1, 1'b0, 1'b0);
        do_write(17'h006, V3, 1'b0, 1'b0);

        // Full read, then OE_N raised while driving.
        start_read(17'h005, 1'b0, 1'b0, V1, 1'b1);
        repeat (LAT + 1) step();
        settle();
        check("drive_rd_valid", rd_valid, 1);
        check("drive_busy", busy, 1);
        oe_n = 1'b1;
        #1;
        check("oe_release_valid", rd_valid, 0);
        check_rel("oe_release_lo", dq[31:0]);
        check_rel("oe_release_hi", dq[63:32]);
        step();
        check("oe_abort_idle", busy, 0);
        idle_bus();

        // Lower-lane write, then full and upper-masked reads.
        do_write(17'h005, {32'h0, 32'hCAFE_BABE}, 1'b0, 1'b1);
        start_read(17'h005, 1'b0, 1'b0, V2, 1'b1);
        repeat (LAT + 1) step();
        settle();
        idle_bus();
        start_read(17'h005, 1'b0, 1'b1, V2, 1'b1);
        repeat (LAT + 1) step();
        settle();
        idle_bus();

        // Address change during RD_WAIT restarts the count.
        start_read(17'h005, 1'b0, 1'b0, V1, 1'b0);
        step();
        addr = 17'h006;
        push_exp(V3, 1'b1, 1'b1);
        repeat (LAT + 1) step();
        settle();
        idle_bus();

        // Aliased write, read back through the low index.
        do_write(17'h405, V4, 1'b0, 1'b0);
        start_read(17'h005, 1'b0, 1'b0, V4, 1'b1);
        repeat (LAT + 1) step();
        settle();
        we_n = 1'b0; tb_dq = V5; tb_dq_en = 1'b1;
        #1;
        check("write_wins_valid", rd_valid, 0);
        step();
        check("write_forces_idle", busy, 0);
        we_n = 1'b1; tb_dq_en = 1'b0;
        push_exp(V5, 1'b1, 1'b1);
        repeat (LAT + 1) step();
        settle();
        idle_bus();

        // Asynchronous reset while driving.
        start_read(17'h006, 1'b0, 1'b0, V3, 1'b1);
        repeat (LAT + 1) step();
        settle();
        rst = 1'b1;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check_rel("rst_dq_lo", dq[31:0]);
        check_rel("rst_dq_hi", dq[63:32]);
        idle_bus();
        step();
        step();
        rst = 1'b0;

        repeat (4) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: %0d reads still pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
